// File: rtl/perf_dump.sv
// Performance counters plus a snapshot dump streamed over a valid/ready port.
// Define PERF_DUMP_MEM_EN to append NMEM data-memory words after the registers.
module perf_dump #(
  parameter int NREG = 32,
  parameter int NMEM = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hazard_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        clr_i,
  input  logic        dump_req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [4:0]  mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  // Output handshake: a word transfers on any rising edge where out_valid_o
  // and out_ready_i are both 1; while valid is high and ready low, out_data_o
  // and out_last_o hold, and valid never drops before the transfer.

`ifdef PERF_DUMP_MEM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_REG = 2'd2, S_MEM = 2'd3} state_t;
  localparam int MEM_WORDS = NMEM;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_REG = 2'd2} state_t;
  localparam int MEM_WORDS = 0 * NMEM;
  logic unused_mem_data;
  assign unused_mem_data = ^mem_data_i;
`endif

  localparam logic [6:0] REG_BASE = 7'd4;
  localparam logic [6:0] MEM_BASE = 7'(4 + NREG);
  localparam logic [6:0] LAST_IDX = 7'(4 + NREG + MEM_WORDS - 1);

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d, flush_q, flush_d;
  logic [31:0] snap_cyc_q, snap_cyc_d, snap_stall_q, snap_stall_d, snap_flush_q, snap_flush_d;

  logic [31:0] cyc_upd, stall_upd, flush_upd;
  logic [6:0]  nxt_idx;
  logic [31:0] nxt_word;
  logic [4:0]  reg_addr, mem_addr;

  function automatic state_t phase_of(input logic [6:0] idx);
    if (idx < REG_BASE) return S_HDR;
`ifdef PERF_DUMP_MEM_EN
    if (idx >= MEM_BASE) return S_MEM;
`endif
    return S_REG;
  endfunction

  // Saturating increments; clear is applied afterwards so the snapshot sees these.
  always_comb begin
    cyc_upd   = (start_i && cyc_q != 32'hFFFF_FFFF) ? cyc_q + 32'd1 : cyc_q;
    stall_upd = (start_i && hazard_i && !jump_i && !branch_i && stall_q != 32'hFFFF_FFFF)
                ? stall_q + 32'd1 : stall_q;
    flush_upd = (start_i && flush_i && flush_q != 32'hFFFF_FFFF) ? flush_q + 32'd1 : flush_q;
    cyc_d     = clr_i ? 32'd0 : cyc_upd;
    stall_d   = clr_i ? 32'd0 : stall_upd;
    flush_d   = clr_i ? 32'd0 : flush_upd;
  end

  // Addresses point at the word that the next transfer will load.
  always_comb begin
    nxt_idx  = idx_q + 7'd1;
    reg_addr = 5'd0;
    mem_addr = 5'd0;
    nxt_word = reg_data_i;
    if (nxt_idx == 7'd1)      nxt_word = snap_cyc_q;
    else if (nxt_idx == 7'd2) nxt_word = snap_stall_q;
    else if (nxt_idx == 7'd3) nxt_word = snap_flush_q;
`ifdef PERF_DUMP_MEM_EN
    else if (nxt_idx >= MEM_BASE) nxt_word = mem_data_i;
`endif
    if (state_q != S_IDLE) begin
      if (nxt_idx >= REG_BASE && nxt_idx < MEM_BASE) reg_addr = 5'(nxt_idx - REG_BASE);
`ifdef PERF_DUMP_MEM_EN
      if (nxt_idx >= MEM_BASE && nxt_idx <= LAST_IDX) mem_addr = 5'(nxt_idx - MEM_BASE);
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    snap_cyc_d   = snap_cyc_q;
    snap_stall_d = snap_stall_q;
    snap_flush_d = snap_flush_q;
    if (state_q == S_IDLE) begin
      if (dump_req_i) begin
        state_d      = S_HDR;
        idx_d        = 7'd0;
        data_d       = pc_i;
        valid_d      = 1'b1;
        last_d       = 1'b0;
        snap_cyc_d   = cyc_upd;
        snap_stall_d = stall_upd;
        snap_flush_d = flush_upd;
      end
    end else if (valid_q && out_ready_i) begin
      if (last_q) begin
        state_d = S_IDLE;
        idx_d   = 7'd0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        state_d = phase_of(nxt_idx);
        idx_d   = nxt_idx;
        data_d  = nxt_word;
        last_d  = (nxt_idx == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= 7'd0;
      data_q       <= 32'd0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      cyc_q        <= 32'd0;
      stall_q      <= 32'd0;
      flush_q      <= 32'd0;
      snap_cyc_q   <= 32'd0;
      snap_stall_q <= 32'd0;
      snap_flush_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      cyc_q        <= cyc_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      snap_cyc_q   <= snap_cyc_d;
      snap_stall_q <= snap_stall_d;
      snap_flush_q <= snap_flush_d;
    end
  end

  assign reg_addr_o  = reg_addr;
  assign mem_addr_o  = mem_addr;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_perf_dump.sv
// Bench for perf_dump: counter model plus expected-word queue per dump.
module tb_perf_dump;
  localparam int NREG = 32;
  localparam int NMEM = 8;
`ifdef PERF_DUMP_MEM_EN
  localparam int NW = 4 + NREG + NMEM;
`else
  localparam int NW = 4 + NREG;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, start_i, hazard_i, jump_i, branch_i, flush_i, clr_i, dump_req_i;
  logic [31:0] pc_i, reg_data_i, mem_data_i, out_data_o;
  logic [4:0]  reg_addr_o, mem_addr_o;
  logic        out_valid_o, out_ready_i, out_last_o, busy_o;
  logic [1:0]  dbg_state_o;

  logic [31:0] regs_m [32];
  logic [31:0] mem_m  [32];
  assign reg_data_i = regs_m[reg_addr_o];
  assign mem_data_i = mem_m[mem_addr_o];

  perf_dump #(.NREG(NREG), .NMEM(NMEM)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hazard_i(hazard_i),
    .jump_i(jump_i), .branch_i(branch_i), .flush_i(flush_i), .pc_i(pc_i),
    .clr_i(clr_i), .dump_req_i(dump_req_i), .reg_addr_o(reg_addr_o),
    .reg_data_i(reg_data_i), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // Reference model state
  logic [31:0] m_cyc, m_stall, m_flush, pc_val;
  int          m_rem, m_pos;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [31:0] ref_q [$];
  int          n_tests, n_fail;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_stall = 0; m_flush = 0; m_rem = 0; m_pos = 0;
  endtask

  // Drive one cycle from a negedge, advance the model, return at the next negedge.
  task automatic tick(input logic st, hz, jp, br, fl, cl, rq, rd);
    logic [31:0] nc, ns, nf;
    start_i = st; hazard_i = hz; jump_i = jp; branch_i = br; flush_i = fl;
    clr_i = cl; dump_req_i = rq; out_ready_i = rd; pc_i = pc_val;
    nc = sat_inc(m_cyc, st);
    ns = sat_inc(m_stall, st && hz && !jp && !br);
    nf = sat_inc(m_flush, st && fl);
    if (m_rem > 0) begin
      if (rd) begin m_rem--; m_pos++; end
    end else if (rq) begin
      exp_q.delete();
      exp_q.push_back(pc_val);
      exp_q.push_back(nc);
      exp_q.push_back(ns);
      exp_q.push_back(nf);
      for (int i = 0; i < NREG; i++) exp_q.push_back(regs_m[i]);
`ifdef PERF_DUMP_MEM_EN
      for (int i = 0; i < NMEM; i++) exp_q.push_back(mem_m[i]);
`endif
      m_rem = NW; m_pos = 0;
    end
    m_cyc   = cl ? 32'd0 : nc;
    m_stall = cl ? 32'd0 : ns;
    m_flush = cl ? 32'd0 : nf;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs the current dump to completion, recording accepted words into got_q.
  task automatic drain(input int mode, input logic st, output int nvalid, output int unstable,
                       output int nlast, output int last_at, output logic timeout);
    logic        rd, pstall;
    logic [33:0] prev;
    got_q.delete();
    nvalid = 0; unstable = 0; nlast = 0; last_at = -1;
    for (int k = 0; k < 1000 && m_rem > 0; k++) begin
      rd = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      if (out_valid_o) nvalid++;
      if (out_valid_o && rd) begin
        got_q.push_back(out_data_o);
        if (out_last_o) begin nlast++; last_at = got_q.size() - 1; end
      end
      prev   = {out_valid_o, out_last_o, out_data_o};
      pstall = out_valid_o && !rd;
      tick(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0, rd);
      if (pstall && {out_valid_o, out_last_o, out_data_o} !== prev) unstable++;
    end
    timeout = (m_rem > 0);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid_o, out_last_o, busy_o, out_data_o, reg_addr_o, mem_addr_o} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%h ra=%0d ma=%0d, want all 0",
               out_valid_o, out_last_o, busy_o, out_data_o, reg_addr_o, mem_addr_o);
    end
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_counters();
    int nv, un, nl, la; logic to;
    for (int i = 0; i < 10; i++)
      tick(1'b1, i < 3, 1'b0, i == 2, i == 5 || i == 6, 1'b0, 1'b0, 1'b1);
    pc_val = $urandom;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain(0, 1'b0, nv, un, nl, la, to);
    n_tests++;
    if (to || got_q.size() != NW) begin
      n_fail++;
      $display("FAIL cnt_dump_len: got %0d words (timeout=%b), want %0d", got_q.size(), to, NW);
    end else begin
      n_tests++;
      if (got_q[1] !== 32'd10) begin n_fail++; $display("FAIL cnt_cycle: got %0d want 10", got_q[1]); end
      n_tests++;
      if (got_q[2] !== 32'd2) begin n_fail++; $display("FAIL cnt_stall: got %0d want 2", got_q[2]); end
      n_tests++;
      if (got_q[3] !== 32'd2) begin n_fail++; $display("FAIL cnt_flush: got %0d want 2", got_q[3]); end
      n_tests++;
      if (got_q[0] !== pc_val) begin n_fail++; $display("FAIL cnt_pc: got %h want %h", got_q[0], pc_val); end
    end
  endtask

  task automatic test_stream();
    int nv, un, nl, la, bad; logic to;
    regs_m[8] = 32'd7;
    mem_m[0]  = 32'h0000_0005;
    pc_val = $urandom;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain(0, 1'b0, nv, un, nl, la, to);
    n_tests++;
    if (to || nv != NW || got_q.size() != NW) begin
      n_fail++;
      $display("FAIL stream_len: got %0d valid cycles, %0d words, want %0d", nv, got_q.size(), NW);
    end else begin
      n_tests++;
      if (got_q[12] !== 32'd7) begin n_fail++; $display("FAIL stream_r8: got %0d want 7", got_q[12]); end
`ifdef PERF_DUMP_MEM_EN
      n_tests++;
      if (got_q[36] !== 32'd5) begin n_fail++; $display("FAIL stream_mem0: got %0d want 5", got_q[36]); end
`endif
      bad = 0;
      for (int i = 0; i < NW; i++) if (got_q[i] !== exp_q[i]) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL stream_words: %0d words differ, want 0", bad); end
    end
    n_tests++;
    if (nl != 1 || la != NW - 1) begin
      n_fail++;
      $display("FAIL stream_last: got %0d last flags at %0d, want 1 at %0d", nl, la, NW - 1);
    end
    n_tests++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: got v=%b b=%b want 0 0", out_valid_o, busy_o);
    end
    ref_q = got_q;
  endtask

  task automatic test_ready_toggle();
    int nv, un, nl, la, bad; logic to;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain(1, 1'b0, nv, un, nl, la, to);
    n_tests++;
    if (un != 0) begin n_fail++; $display("FAIL toggle_stable: got %0d changes during stall, want 0", un); end
    bad = (got_q.size() != ref_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) if (got_q[i] !== ref_q[i]) bad++;
    n_tests++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL toggle_seq: got %0d words with %0d differences, want %0d equal", got_q.size(), bad, ref_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int pos, zeros, bad_gap, ngaps, mism, nv, un, nl, la; logic seen, to;
    logic [31:0] hdr [$];
    pos = 0; zeros = 0; bad_gap = 0; ngaps = 0; mism = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid_o) begin
        if (seen && zeros > 0) begin ngaps++; if (zeros != 1) bad_gap++; end
        if (pos == 1) hdr.push_back(out_data_o);
        pos++; zeros = 0; seen = 1'b1;
      end else begin
        pos = 0; zeros++;
      end
      pc_val = $urandom;
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
      if ({out_valid_o, busy_o} !== {2{m_rem > 0}} ||
          (m_rem > 0 && {out_last_o, out_data_o} !== {m_rem == 1, exp_q[m_pos]})) mism++;
    end
    n_tests++;
    if (mism != 0) begin n_fail++; $display("FAIL b2b_model: got %0d cycle mismatches, want 0", mism); end
    n_tests++;
    if (bad_gap != 0 || ngaps < 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d gaps, %0d not one cycle, want >=1 and 0", ngaps, bad_gap);
    end
    n_tests++;
    if (hdr.size() < 2 || hdr[1] <= hdr[0]) begin
      n_fail++;
      $display("FAIL b2b_hdr: got %0d headers, want >=2 with increasing cycle", hdr.size());
    end
    drain(0, 1'b0, nv, un, nl, la, to);
  endtask

  task automatic test_random();
    int mism, nv, un, nl, la; logic to;
    mism = 0;
    for (int i = 0; i < NREG; i++) regs_m[i] = $urandom;
    for (int i = 0; i < 32; i++) mem_m[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      pc_val = $urandom;
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
      if ({out_valid_o, busy_o} !== {2{m_rem > 0}} ||
          (m_rem > 0 && {out_last_o, out_data_o} !== {m_rem == 1, exp_q[m_pos]}) ||
          (m_rem == 0 && {reg_addr_o, mem_addr_o} !== 10'd0)) mism++;
    end
    n_tests++;
    if (mism != 0) begin n_fail++; $display("FAIL random_model: got %0d cycle mismatches, want 0", mism); end
    drain(2, 1'b0, nv, un, nl, la, to);
    n_tests++;
    if (to || un != 0) begin n_fail++; $display("FAIL random_drain: timeout=%b unstable=%0d, want 0 0", to, un); end
  endtask

  task automatic test_clr_reset();
    logic [31:0] w [$];
    int nv;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    pc_val = $urandom;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o) w.push_back(out_data_o);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_tests++;
    if (w.size() != 20 || {w[1], w[2], w[3]} !== 96'd0) begin
      n_fail++;
      $display("FAIL clr_hdr: got %0d words, counters not all 0, want 20 words with 0 0 0", w.size());
    end
    rst_i = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid_o, out_last_o, busy_o, out_data_o, reg_addr_o, mem_addr_o} !== 45'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b l=%b b=%b d=%h ra=%0d ma=%0d, want all 0",
               out_valid_o, out_last_o, busy_o, out_data_o, reg_addr_o, mem_addr_o);
    end
    @(negedge clk); @(negedge clk);
    rst_i = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (out_valid_o !== 1'b0) nv++;
    end
    n_tests++;
    if (nv != 0) begin n_fail++; $display("FAIL midreset_resume: got %0d valid cycles, want 0", nv); end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'd3) begin
      n_fail++;
      $display("FAIL post_reset_count: got v=%b cycle=%0d, want 1 and 3", out_valid_o, out_data_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; pc_val = 32'd0;
    start_i = 0; hazard_i = 0; jump_i = 0; branch_i = 0; flush_i = 0;
    clr_i = 0; dump_req_i = 0; out_ready_i = 0; pc_i = 0;
    for (int i = 0; i < 32; i++) begin regs_m[i] = $urandom; mem_m[i] = $urandom; end
    test_reset();
    test_counters();
    test_stream();
    test_ready_toggle();
    test_back_to_back();
    test_random();
    test_clr_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
